// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------
// fetch_pkg: shared FSM encodings, opcode default, range helper
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;
  localparam logic [1:0] JMP_OPC_DEF = 2'b11;

  // True when a target address lies outside the loaded program.
  function automatic logic out_of_range(input logic [7:0] tgt, input int len);
    return int'(tgt) >= len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------
// fetch_next_pc: combinational next-PC candidates and range checks
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int         PROG_LEN = 7,
  parameter logic [1:0] JMP_OPC  = JMP_OPC_DEF
) (
  input  logic [7:0] pc,
  input  logic [7:0] ins_code,
  input  logic [7:0] redir_pc,
  output logic [7:0] seq_pc,
  output logic       is_jump,
  output logic [7:0] jump_pc,
  output logic       jump_bad,
  output logic [7:0] redir_tgt,
  output logic       redir_bad
);

  logic [7:0] jump_raw;

  always_comb begin
    seq_pc    = (pc == 8'(PROG_LEN - 1)) ? 8'd0 : pc + 8'd1;
    is_jump   = (ins_code[7:6] == JMP_OPC);
    jump_raw  = {2'b00, ins_code[5:0]};
    // Out-of-range targets collapse to address 0 and raise the error.
    jump_bad  = out_of_range(jump_raw, PROG_LEN);
    jump_pc   = jump_bad ? 8'd0 : jump_raw;
    redir_bad = out_of_range(redir_pc, PROG_LEN);
    redir_tgt = redir_bad ? 8'd0 : redir_pc;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------
// fetch_ctrl: fetch FSM driving instruction memory and issue slot
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         PROG_LEN = 7,
  parameter logic [1:0] JMP_OPC  = JMP_OPC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt_req,
  input  logic       redir_valid,
  input  logic [7:0] redir_pc,
  output logic [7:0] pc,
  input  logic [7:0] ins_code,
  output logic       out_valid,
  output logic [7:0] out_ins,
  output logic [7:0] out_pc,
  input  logic       out_ready,
  output logic [1:0] state,
  output logic       jump_err
);

  logic [1:0] state_next;
  logic       slot_free;
  logic       xfer;
  logic       do_issue;
  logic       do_jump;
  logic [7:0] seq_pc;
  logic       is_jump;
  logic [7:0] jump_pc;
  logic       jump_bad;
  logic [7:0] redir_tgt;
  logic       redir_bad;

  fetch_next_pc #(
    .PROG_LEN (PROG_LEN),
    .JMP_OPC  (JMP_OPC)
  ) u_next_pc (
    .pc        (pc),
    .ins_code  (ins_code),
    .redir_pc  (redir_pc),
    .seq_pc    (seq_pc),
    .is_jump   (is_jump),
    .jump_pc   (jump_pc),
    .jump_bad  (jump_bad),
    .redir_tgt (redir_tgt),
    .redir_bad (redir_bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A redirect freezes the FSM for that cycle; start wins over halt outside RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HALT: if (start && !redir_valid)    state_next = ST_RUN;
      ST_RUN:           if (halt_req && !redir_valid) state_next = ST_HALT;
      default:                                         state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_free = !out_valid || out_ready;
    xfer      = out_valid && out_ready;
    do_issue  = 1'b0;
    do_jump   = 1'b0;
    if (state == ST_RUN && !redir_valid && !halt_req && slot_free) begin
      do_issue = !is_jump;
      do_jump  = is_jump;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= 8'd0;
      out_valid <= 1'b0;
      out_ins   <= 8'd0;
      out_pc    <= 8'd0;
      jump_err  <= 1'b0;
    end else if (redir_valid) begin
      pc        <= redir_tgt;
      out_valid <= 1'b0;
      if (redir_bad) jump_err <= 1'b1;
    end else if (do_jump) begin
      // Jumps are consumed here; the slot empties, leaving a bubble.
      pc        <= jump_pc;
      out_valid <= 1'b0;
      if (jump_bad) jump_err <= 1'b1;
    end else if (do_issue) begin
      out_ins   <= ins_code;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= seq_pc;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PROG_LEN, default 7, the number of valid instruction-memory words; the legal PC range is 0..PROG_LEN-1.
REQ-002 SHALL have parameter JMP_OPC, default 2'b11, the ins[7:6] opcode treated as an absolute jump.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin or resume fetching.
REQ-006 SHALL have port halt_req, input, 1 bit: stop fetching new instructions.
REQ-007 SHALL have port redir_valid, input, 1 bit: external PC redirect.
REQ-008 SHALL have port redir_pc, input, 8 bits: redirect target.
REQ-009 SHALL have port pc, output, 8 bits: registered fetch address driven to the instruction memory.
REQ-010 SHALL have port ins_code, input, 8 bits: memory word at pc, valid in the same cycle (combinational read).
REQ-011 SHALL have port out_valid, output, 1 bit: the issue slot holds an instruction.
REQ-012 SHALL have port out_ins, output, 8 bits: the issued instruction.
REQ-013 SHALL have port out_pc, output, 8 bits: the address of out_ins.
REQ-014 SHALL have port out_ready, input, 1 bit: the decoder accepts the slot.
REQ-015 SHALL have port state, output, 2 bits: current FSM state.
REQ-016 SHALL have port jump_err, output, 1 bit: sticky out-of-range target flag.

Function
REQ-017 SHALL implement the FSM states IDLE=0, RUN=1 and HALT=2; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-018 SHALL transition IDLE->RUN and HALT->RUN when start=1; RUN->HALT when halt_req=1; all other cases hold the current state.
REQ-019 SHALL define the slot as free when out_valid=0 or out_ready=1, and a transfer as out_valid=1 with out_ready=1.
REQ-020 SHALL, in RUN with a free slot and ins_code[7:6]!=JMP_OPC, load out_ins<=ins_code, out_pc<=pc and out_valid<=1, and advance pc to pc+1, wrapping to 0 when pc==PROG_LEN-1.
REQ-021 SHALL, in RUN with a free slot and ins_code[7:6]==JMP_OPC, not issue the jump, load pc<={2'b00,ins_code[5:0]}, and clear out_valid if the slot transferred, giving a one-cycle bubble.
REQ-022 SHALL hold pc, out_ins, out_pc and out_valid in RUN while the slot is not free (stall).
REQ-023 SHALL NOT fetch new instructions in IDLE or HALT; an already-valid slot SHALL be held until it transfers, then out_valid<=0.
REQ-024 SHALL apply this priority in the same cycle: redir_valid > halt_req > jump > sequential fetch.
REQ-025 SHALL, when redir_valid=1 in any state, load pc<=redir_pc, set out_valid<=0 (flush, even if out_ready=0), and leave the FSM state unchanged.
REQ-026 SHALL, when halt_req=1 in RUN, perform no fetch that cycle.
REQ-027 SHALL, for any jump or redirect target >= PROG_LEN, load pc<=0 and set jump_err=1; jump_err SHALL clear only on reset.
REQ-028 SHALL take start and halt_req both high in RUN as a halt, and in IDLE or HALT as a start.

Reset
REQ-029 SHALL, while reset=0, asynchronously force pc=0, out_valid=0, out_ins=0, out_pc=0, state=IDLE and jump_err=0.
REQ-030 SHALL discard any in-flight slot and stalled state on reset assertion mid-operation, with no issue in the first cycle after release.
REQ-031 SHALL remain in IDLE after reset release until start=1.

Structure
REQ-032 SHALL place the state encodings IDLE/RUN/HALT and the JMP_OPC default in the shared package fetch_pkg.
REQ-033 SHALL implement the next-PC computation (sequential wrap, jump target, redirect, range check producing the error) as the combinational sub-module fetch_next_pc, instantiated once.
REQ-034 SHALL keep all registers in fetch_ctrl.

Verification
Memory image used: 0:1B, 1:53, 2:5A, 3:C1, 4:1B, 5:5B, 6:58.
REQ-035 SHALL cover: reset release, start=1 for one cycle, out_ready=1 -> issued out_pc sequence 0,1,2, then a bubble, then 1,2,(bubble),1..., and jump 0xC1 never issued.
REQ-036 SHALL cover: out_ready=0 while out_pc=1 is valid for 3 cycles -> out_ins=53 and pc=2 held, with no loss or duplication after ready returns.
REQ-037 SHALL cover: redir_valid=1 with redir_pc=5 while the slot holds pc 2 and out_ready=0 -> slot flushed, next issues 5 (5B), then 6 (58), then 0 (wrap).
REQ-038 SHALL cover: redir_pc=9 -> pc=0 and jump_err=1, held after 20 cycles; cleared only by reset.
REQ-039 SHALL cover: halt_req=1 during RUN with a valid slot -> state=HALT, slot transfers once, no further issues; start=1 -> resumes at the held pc.
REQ-040 SHALL cover: reset pulled low mid-stall -> all outputs zero immediately, state=IDLE.
